// File: rtl/gpr_pkg.sv
// Shared types for the GPR writeback slice.
// Register-address width, file size and writeback request bundle.
package gpr_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;
   localparam int GPR_DATA_W = 64;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [GPR_DATA_W-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/gpr_wb_unit_if.sv
// Valid/ready channel carrying long-latency LSU/MDU results
// into the writeback unit.
interface gpr_wb_unit_if
   import gpr_pkg::*;
#(
   parameter int DATA_W = GPR_DATA_W
);

   logic                  valid;
   logic                  ready;
   logic [REG_ADDR_W-1:0] rd;
   logic [DATA_W-1:0]     data;

   modport master (
      output valid,
      output rd,
      output data,
      input  ready
   );

   modport slave (
      input  valid,
      input  rd,
      input  data,
      output ready
   );

endinterface

// File: rtl/gpr_wb_unit_fifo.sv
// Synchronous FIFO of writeback requests; the head entry
// is visible combinationally so the arbiter can pop same-cycle.
module wb_fifo
   import gpr_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  wb_req_t                  wdata,
   output wb_req_t                  rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   wb_req_t         mem [DEPTH];
   logic [AW-1:0]   wptr;
   logic [AW-1:0]   rptr;

   // Power-of-2 depth: pointers wrap by natural overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= wdata;
   end

   assign rdata = mem[rptr];
   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);

endmodule

// File: rtl/gpr_wb_unit.sv
// Writeback producer: merges ALU and buffered LSU/MDU results
// into the GPR write port and tracks pending writes for RAW stalls.
module gpr_wb_unit
   import gpr_pkg::*;
#(
   parameter int DATA_W     = GPR_DATA_W,
   parameter int B_DEPTH    = 4,
   parameter int STARVE_MAX = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  a_valid_i,
   input  logic [REG_ADDR_W-1:0] a_rd_i,
   input  logic [DATA_W-1:0]     a_data_i,
   gpr_wb_unit_if.slave          b,
   input  logic                  issue_i,
   input  logic [REG_ADDR_W-1:0] issue_rd_i,
   output logic [REG_ADDR_W-1:0] Rd_o,
   output logic [DATA_W-1:0]     Rd_data_o,
   output logic                  Rd_wen_o,
   output logic [NUM_REGS-1:0]   pend_o,
   output logic                  stall_req_o
);

   localparam int CW = $clog2(B_DEPTH) + 1;
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] FULL_CNT   = CW'(B_DEPTH);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

   wb_req_t               a_req;
   wb_req_t               b_req;
   wb_req_t               head;
   wb_req_t               sel;
   logic                  sel_v;
   logic                  push;
   logic                  pop;
   logic                  full;
   logic                  empty;
   logic [CW-1:0]         count;
   logic                  rdy_q;
   logic [SW-1:0]         starve_cnt;
   logic [SW-1:0]         cnt_nxt;
   logic [NUM_REGS-1:0]   pend_nxt;

   assign a_req = '{rd: a_rd_i, data: a_data_i};
   assign b_req = '{rd: b.rd, data: b.data};

   // rdy_q keeps ready low while reset is held, without an input path.
   assign b.ready = rdy_q && (count != FULL_CNT);
   assign push    = b.valid && b.ready;

   wb_fifo #(
      .DEPTH (B_DEPTH)
   ) u_fifo (
      .clk   (clk_i),
      .rst_n (rst_i),
      .push  (push),
      .pop   (pop),
      .wdata (b_req),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   always_comb begin
      sel   = '0;
      sel_v = 1'b0;
      pop   = 1'b0;
      if (a_valid_i) begin
         sel   = a_req;
         sel_v = 1'b1;
      end else if (!empty) begin
         sel   = head;
         sel_v = 1'b1;
         pop   = 1'b1;
      end
   end

   always_comb begin
      cnt_nxt = starve_cnt;
      if (pop || empty) begin
         cnt_nxt = '0;
      end else if (a_valid_i && starve_cnt != STARVE_LIM) begin
         cnt_nxt = starve_cnt + 1'b1;
      end
   end

   // Set is applied after clear so a newer producer stays pending.
   always_comb begin
      pend_nxt = pend_o;
      if (sel_v) pend_nxt[sel.rd] = 1'b0;
      if (issue_i) pend_nxt[issue_rd_i] = 1'b1;
      pend_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         rdy_q       <= 1'b0;
         starve_cnt  <= '0;
         stall_req_o <= 1'b0;
         pend_o      <= '0;
         Rd_o        <= '0;
         Rd_data_o   <= '0;
         Rd_wen_o    <= 1'b0;
      end else begin
         rdy_q       <= 1'b1;
         starve_cnt  <= cnt_nxt;
         stall_req_o <= (cnt_nxt >= STARVE_LIM);
         pend_o      <= pend_nxt;
         Rd_wen_o    <= sel_v && (sel.rd != '0);
         if (sel_v && sel.rd != '0) begin
            Rd_o      <= sel.rd;
            Rd_data_o <= sel.data;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         assert (!(stall_req_o && a_valid_i))
            else $error("gpr_wb_unit: a_valid_i asserted during stall_req_o");
         assert (!(push && full))
            else $error("gpr_wb_unit: push into full B buffer");
      end
   end

endmodule

// File: tb/tb_gpr_wb_unit.sv
// Directed self-checking bench for gpr_wb_unit.
// Linear sequence of steps with hand-computed expectations.
module tb_gpr_wb_unit;
   import gpr_pkg::*;

   logic        clk;
   logic        rst;
   logic        a_valid;
   logic [4:0]  a_rd;
   logic [63:0] a_data;
   logic        issue;
   logic [4:0]  issue_rd;
   logic [4:0]  rd_o;
   logic [63:0] rd_data;
   logic        rd_wen;
   logic [31:0] pend;
   logic        stall;

   int nvec = 0;
   int nerr = 0;

   gpr_wb_unit_if #(.DATA_W(64)) bif ();

   gpr_wb_unit #(
      .DATA_W     (64),
      .B_DEPTH    (4),
      .STARVE_MAX (8)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .a_valid_i   (a_valid),
      .a_rd_i      (a_rd),
      .a_data_i    (a_data),
      .b           (bif.slave),
      .issue_i     (issue),
      .issue_rd_i  (issue_rd),
      .Rd_o        (rd_o),
      .Rd_data_o   (rd_data),
      .Rd_wen_o    (rd_wen),
      .pend_o      (pend),
      .stall_req_o (stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      nvec++;
      assert (obs === exp)
      else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv_a(input logic v, input logic [4:0] r,
                        input logic [63:0] d);
      a_valid = v;
      a_rd    = r;
      a_data  = d;
   endtask

   task automatic drv_b(input logic v, input logic [4:0] r,
                        input logic [63:0] d);
      bif.valid = v;
      bif.rd    = r;
      bif.data  = d;
   endtask

   initial begin
      rst      = 1'b0;
      issue    = 1'b0;
      issue_rd = '0;
      drv_a(1'b0, 5'd0, 64'h0);
      drv_b(1'b0, 5'd0, 64'h0);
      #3;
      chk("rst_wen",   rd_wen,  0);
      chk("rst_rd",    rd_o,    0);
      chk("rst_data",  rd_data, 0);
      chk("rst_pend",  pend,    0);
      chk("rst_stall", stall,   0);
      chk("rst_ready", bif.ready, 0);
      #9;
      rst = 1'b1;
      tick();
      chk("ready_after_rst", bif.ready, 1);

      // 1: single A write
      drv_a(1'b1, 5'd5, 64'h1234);
      tick();
      chk("t1_wen",  rd_wen,  1);
      chk("t1_rd",   rd_o,    5);
      chk("t1_data", rd_data, 64'h1234);

      // 2: A and B together, B follows one cycle later
      drv_a(1'b1, 5'd3, 64'hAA);
      drv_b(1'b1, 5'd7, 64'hBB);
      tick();
      chk("t2_rd_a",   rd_o,    3);
      chk("t2_data_a", rd_data, 64'hAA);
      drv_a(1'b0, 5'd0, 64'h0);
      drv_b(1'b0, 5'd0, 64'h0);
      tick();
      chk("t2_wen_b",  rd_wen,  1);
      chk("t2_rd_b",   rd_o,    7);
      chk("t2_data_b", rd_data, 64'hBB);
      tick();
      chk("t2_idle_wen", rd_wen, 0);
      chk("t2_hold_rd",  rd_o,   7);

      // 4: rd=0 produces no write
      drv_a(1'b1, 5'd0, 64'hFFFF);
      tick();
      chk("t4_wen",  rd_wen,  0);
      chk("t4_rd",   rd_o,    7);
      chk("t4_data", rd_data, 64'hBB);
      chk("t4_pend", pend,    0);
      drv_a(1'b0, 5'd0, 64'h0);

      // 5: scoreboard set/clear, set wins
      issue = 1'b1; issue_rd = 5'd9;
      tick();
      chk("t5_set", pend, 32'h200);
      issue = 1'b0;
      tick();
      chk("t5_hold", pend, 32'h200);
      drv_a(1'b1, 5'd9, 64'h99);
      tick();
      chk("t5_wen",   rd_wen, 1);
      chk("t5_clear", pend,   0);
      drv_a(1'b0, 5'd0, 64'h0);
      issue = 1'b1;
      tick();
      chk("t5_reset", pend, 32'h200);
      drv_a(1'b1, 5'd9, 64'h77);
      tick();
      chk("t5_wen2",   rd_wen,  1);
      chk("t5_data2",  rd_data, 64'h77);
      chk("t5_setwin", pend,    32'h200);
      issue = 1'b0;
      tick();
      chk("t5_clear2", pend, 0);

      // 3: fill buffer under continuous A, starvation, drain
      for (int k = 0; k < 4; k++) begin
         drv_a(1'b1, 5'd1, 64'(k));
         drv_b(1'b1, 5'(20 + k), 64'(8'hB0 + k));
         chk($sformatf("t3_ready%0d", k), bif.ready, 1);
         tick();
         chk($sformatf("t3_arun%0d", k), rd_data, 64'(k));
      end
      drv_b(1'b1, 5'd24, 64'hB4);
      chk("t3_full", bif.ready, 0);
      for (int k = 4; k < 9; k++) begin
         drv_a(1'b1, 5'd1, 64'(k));
         tick();
         if (k == 7) chk("t3_stall7", stall, 0);
      end
      chk("t3_stall8", stall, 1);
      chk("t3_still_full", bif.ready, 0);
      drv_a(1'b0, 5'd0, 64'h0);
      tick();
      chk("t3_pop0_rd",   rd_o,    20);
      chk("t3_pop0_data", rd_data, 64'hB0);
      chk("t3_stall_clr", stall,   0);
      chk("t3_ready_ret", bif.ready, 1);
      tick();
      chk("t3_pop1_rd", rd_o, 21);
      drv_b(1'b0, 5'd0, 64'h0);
      tick();
      chk("t3_pop2_rd", rd_o, 22);
      tick();
      chk("t3_pop3_rd", rd_o, 23);
      tick();
      chk("t3_pop4_rd",   rd_o,    24);
      chk("t3_pop4_data", rd_data, 64'hB4);
      tick();
      chk("t3_empty_wen", rd_wen, 0);

      // 6: reset mid-operation discards buffer and pend bits
      drv_a(1'b1, 5'd0, 64'h0);
      issue = 1'b1; issue_rd = 5'd9;
      drv_b(1'b1, 5'd9, 64'hC0);
      tick();
      issue_rd = 5'd10;
      drv_b(1'b1, 5'd10, 64'hC1);
      tick();
      issue = 1'b0; issue_rd = 5'd0;
      drv_b(1'b1, 5'd11, 64'hC2);
      tick();
      chk("t6_pend", pend, 32'h600);
      drv_a(1'b0, 5'd0, 64'h0);
      drv_b(1'b0, 5'd0, 64'h0);
      #1;
      rst = 1'b0;
      #1;
      chk("t6_rst_wen",   rd_wen,  0);
      chk("t6_rst_rd",    rd_o,    0);
      chk("t6_rst_data",  rd_data, 0);
      chk("t6_rst_pend",  pend,    0);
      chk("t6_rst_ready", bif.ready, 0);
      #2;
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("t6_nowr%0d", k), rd_wen, 0);
      end
      chk("t6_pend_after", pend, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
